// File: rtl/maze_letter_reveal.sv
// maze_letter_reveal
// Writer side of the letter-grid display path. Owns the reveal bitmap read by
// the letter renderer. Each accepted guess triggers a row-major scan of the
// fixed letter layout, one cell per cycle, and sets the bit of every cell whose
// code equals the guess.
//
// Ports:
//   Clk, Reset       system clock, synchronous active-high reset
//   guess_valid/code guess request and its letter code
//   guess_ready      high in IDLE; guess taken on guess_valid & guess_ready
//   clear            hide all letters and abort any scan (new game)
//   rd_y, rd_x       layout cell address being read
//   rd_code          layout code at (rd_y, rd_x), combinational
//   maze_letters     reveal bitmap, maze_letters[y][x] = 1 means shown
//   busy             scan in progress
//   done             one-cycle pulse at scan end
//   hit, new_count,  scan results, valid only while done is high
//   all_revealed
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a guess, guess_ready = 1
// SCAN  | examining one layout cell per cycle, busy = 1
// DONE  | single cycle, done = 1 and results presented

module maze_letter_reveal #(
    parameter int         size_y     = 20,
    parameter int         size_x     = 40,
    parameter logic [7:0] BLANK_CODE = 8'h00
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  guess_valid,
    input  logic [7:0]                            guess_code,
    output logic                                  guess_ready,
    input  logic                                  clear,
    output logic [$clog2(size_y)-1:0]             rd_y,
    output logic [$clog2(size_x)-1:0]             rd_x,
    input  logic [7:0]                            rd_code,
    output logic [size_y-1:0][0:size_x-1]         maze_letters,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  hit,
    output logic [$clog2(size_x*size_y+1)-1:0]    new_count,
    output logic                                  all_revealed
);

    localparam int YW = $clog2(size_y);
    localparam int XW = $clog2(size_x);
    localparam int CW = $clog2(size_x*size_y+1);

    localparam logic [YW-1:0] Y_LAST = YW'(size_y - 1);
    localparam logic [XW-1:0] X_LAST = XW'(size_x - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    guess_q;
    logic          hit_q;
    logic [CW-1:0] new_q;
    logic [CW-1:0] unrev_q;

    logic accept;
    logic last_cell;
    logic cur_bit;
    logic cell_blank;
    logic cell_match;

    assign accept     = (state == IDLE) && guess_valid;
    assign last_cell  = (rd_y == Y_LAST) && (rd_x == X_LAST);
    assign cur_bit    = maze_letters[rd_y][rd_x];
    assign cell_blank = (rd_code == BLANK_CODE);
    assign cell_match = !cell_blank && (rd_code == guess_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (guess_valid) state_nxt = SCAN;
            SCAN:    if (last_cell)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // clear aborts a scan without ever reaching DONE
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            maze_letters <= '0;
            rd_y         <= '0;
            rd_x         <= '0;
            guess_q      <= '0;
            hit_q        <= 1'b0;
            new_q        <= '0;
            unrev_q      <= '0;
        end else if (accept) begin
            guess_q <= guess_code;
            hit_q   <= 1'b0;
            new_q   <= '0;
            unrev_q <= '0;
            rd_y    <= '0;
            rd_x    <= '0;
        end else if (state == SCAN) begin
            if (cell_match) begin
                maze_letters[rd_y][rd_x] <= 1'b1;
                hit_q                    <= 1'b1;
                if (!cur_bit) new_q <= new_q + 1'b1;
            end else if (!cell_blank && !cur_bit) begin
                unrev_q <= unrev_q + 1'b1;
            end

            if (rd_x == X_LAST) begin
                rd_x <= '0;
                rd_y <= last_cell ? '0 : rd_y + 1'b1;
            end else begin
                rd_x <= rd_x + 1'b1;
            end
        end
    end

    assign guess_ready  = (state == IDLE);
    assign busy         = (state == SCAN);
    assign done         = (state == DONE);
    assign hit          = done && hit_q;
    assign new_count    = done ? new_q : '0;
    assign all_revealed = done && (unrev_q == '0);

endmodule

// File: tb/tb_maze_letter_reveal.sv
module tb_maze_letter_reveal;

    localparam int SY = 20;
    localparam int SX = 40;
    localparam int N  = SY * SX;

    logic              Clk;
    logic              Reset;
    logic              guess_valid;
    logic [7:0]        guess_code;
    logic              guess_ready;
    logic              clear;
    logic [4:0]        rd_y;
    logic [5:0]        rd_x;
    logic [7:0]        rd_code;
    logic [SY-1:0][0:SX-1] maze_letters;
    logic              busy;
    logic              done;
    logic              hit;
    logic [9:0]        new_count;
    logic              all_revealed;

    logic [7:0]        layout [SY][SX];
    logic [SY-1:0][0:SX-1] exp_bits;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int   cyc;
        logic hit;
        int   newc;
        logic all;
    } exp_t;

    exp_t sb [$];

    maze_letter_reveal dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .guess_valid  (guess_valid),
        .guess_code   (guess_code),
        .guess_ready  (guess_ready),
        .clear        (clear),
        .rd_y         (rd_y),
        .rd_x         (rd_x),
        .rd_code      (rd_code),
        .maze_letters (maze_letters),
        .busy         (busy),
        .done         (done),
        .hit          (hit),
        .new_count    (new_count),
        .all_revealed (all_revealed)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    always_comb rd_code = layout[rd_y][rd_x];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge Clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle",   cyc,          e.cyc);
                check("hit",          hit,          e.hit);
                check("new_count",    new_count,    e.newc);
                check("all_revealed", all_revealed, e.all);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic blank_layout();
        for (int y = 0; y < SY; y++)
            for (int x = 0; x < SX; x++)
                layout[y][x] = 8'h00;
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("scoreboard_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge Clk);
    endtask

    // issue a guess at a negedge in IDLE and wait for its done pulse
    task automatic run_guess(input logic [7:0] code, input logic h, input int nc, input logic a);
        exp_t e;
        guess_valid = 1'b1;
        guess_code  = code;
        e.cyc = cyc + N + 1;
        e.hit = h;
        e.newc = nc;
        e.all = a;
        sb.push_back(e);
        @(negedge Clk);
        guess_valid = 1'b0;
        wait_sb_empty();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     guess_ready,  1);
        check({tag, "_busy"},      busy,         0);
        check({tag, "_done"},      done,         0);
        check({tag, "_hit"},       hit,          0);
        check({tag, "_new_count"}, new_count,    0);
        check({tag, "_all"},       all_revealed, 0);
        check({tag, "_rd_y"},      rd_y,         0);
        check({tag, "_rd_x"},      rd_x,         0);
        check({tag, "_bits"},      $countones(maze_letters), 0);
    endtask

    initial begin
        int acc;
        int bad;
        Reset       = 1'b1;
        guess_valid = 1'b0;
        guess_code  = 8'h00;
        clear       = 1'b0;
        exp_bits    = '0;
        blank_layout();

        repeat (2) @(negedge Clk);
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // test 1: 'A' at three cells, rest blank
        layout[0][0]  = 8'h41;
        layout[0][5]  = 8'h41;
        layout[3][39] = 8'h41;
        run_guess(8'h41, 1, 3, 1);
        exp_bits = '0;
        exp_bits[0][0]  = 1'b1;
        exp_bits[0][5]  = 1'b1;
        exp_bits[3][39] = 1'b1;
        check("t1_bits", $countones(maze_letters ^ exp_bits), 0);

        pulse_clear();
        check("clear_bits",  $countones(maze_letters), 0);
        check("clear_ready", guess_ready, 1);

        // test 2: "CAT" in row 2
        blank_layout();
        layout[2][0] = 8'h43;
        layout[2][1] = 8'h41;
        layout[2][2] = 8'h54;
        exp_bits = '0;
        run_guess(8'h43, 1, 1, 0);
        exp_bits[2][0] = 1'b1;
        check("t2c_bits", $countones(maze_letters ^ exp_bits), 0);
        run_guess(8'h54, 1, 1, 0);
        exp_bits[2][2] = 1'b1;
        check("t2t_bits", $countones(maze_letters ^ exp_bits), 0);
        run_guess(8'h41, 1, 1, 1);
        exp_bits[2][1] = 1'b1;
        check("t2a_bits", $countones(maze_letters ^ exp_bits), 0);

        // test 3: absent letter, then repeat of a revealed letter
        run_guess(8'h5A, 0, 0, 1);
        check("t3z_bits", $countones(maze_letters ^ exp_bits), 0);
        run_guess(8'h43, 1, 0, 1);
        check("t3c_bits", $countones(maze_letters ^ exp_bits), 0);

        // test 4: guess_valid held high through the scan
        pulse_clear();
        begin
            exp_t e;
            guess_valid = 1'b1;
            guess_code  = 8'h41;
            acc = cyc;
            e.cyc = acc + N + 1;
            e.hit = 1'b1;
            e.newc = 1;
            e.all = 1'b0;
            sb.push_back(e);
        end
        bad = 0;
        repeat (N + 1) begin
            @(negedge Clk);
            if (guess_ready) bad++;
        end
        guess_valid = 1'b0;
        check("t4_ready_low_cycles", bad, 0);
        @(negedge Clk);
        check("t4_ready_back", guess_ready, 1);
        check("t4_ready_cycle", cyc, acc + N + 2);
        repeat (3) @(negedge Clk);
        check("t4_no_second_scan", busy, 0);
        check("t4_sb_drained", sb.size(), 0);

        // test 5: clear on cycle 400 of a scan
        pulse_clear();
        guess_valid = 1'b1;
        guess_code  = 8'h43;
        acc = cyc;
        @(negedge Clk);
        guess_valid = 1'b0;
        while (cyc < acc + 400) @(negedge Clk);
        check("t5_bit_before_clear", maze_letters[2][0], 1);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        check("t5_bits_cleared", $countones(maze_letters), 0);
        check("t5_ready", guess_ready, 1);
        check("t5_busy", busy, 0);
        begin
            exp_t e;
            guess_valid = 1'b1;
            guess_code  = 8'h54;
            acc = cyc;
            e.cyc = acc + N + 1;
            e.hit = 1'b1;
            e.newc = 1;
            e.all = 1'b0;
            sb.push_back(e);
        end
        @(negedge Clk);
        guess_valid = 1'b0;
        check("t5_restart_y", rd_y, 0);
        check("t5_restart_x", rd_x, 0);
        @(negedge Clk);
        check("t5_step_x", rd_x, 1);
        wait_sb_empty();
        exp_bits = '0;
        exp_bits[2][2] = 1'b1;
        check("t5_bits", $countones(maze_letters ^ exp_bits), 0);

        // test 6: Reset mid-scan, then a blank guess
        guess_valid = 1'b1;
        guess_code  = 8'h41;
        acc = cyc;
        @(negedge Clk);
        guess_valid = 1'b0;
        while (cyc < acc + 300) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_reset_outputs("t6_reset");
        run_guess(8'h00, 0, 0, 0);
        check("t6_blank_bits", $countones(maze_letters), 0);

        // layout with no letters at all
        blank_layout();
        run_guess(8'h41, 0, 0, 1);

        repeat (3) @(negedge Clk);
        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
